stream_rr_arbiter: RTL and testbench

//   Per-output-port packet arbiter for the stream crossbar. One instance per master

---
 rtl/stream_rr_arbiter.sv | 115 +++++++++++
 tb/tb_stream_rr_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// Per-output round-robin packet arbiter: grant registered 1 cycle after request, locked until TLAST beat.
// Backpressure: lock holds while ready_i or req_i[grant] is low; no beats are dropped or owed.
module stream_rr_arbiter #(
    parameter int  S_DATA_COUNT = 2,
    localparam int IDX_W        = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [S_DATA_COUNT-1:0] req_i,
    input  logic [S_DATA_COUNT-1:0] last_i,
    input  logic                    ready_i,
    output logic [S_DATA_COUNT-1:0] grant_o,
    output logic                    grant_valid_o,
    output logic [IDX_W-1:0]        grant_idx_o
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic                    valid_q, valid_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [S_DATA_COUNT-1:0] grant_q, grant_d;

    logic                    beat;
    logic                    arb_en;
    logic [IDX_W-1:0]        arb_ptr;
    logic [S_DATA_COUNT-1:0] arb_cand;
    logic                    found;
    logic [IDX_W-1:0]        win;
    int                      pos;
    int                      next_ptr;

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        beat     = req_i[idx_q] & ready_i;
        arb_en   = 1'b0;
        arb_ptr  = ptr_q;
        arb_cand = req_i;
        found    = 1'b0;
        win      = '0;
        pos      = 0;
        next_ptr = (int'(idx_q) + 1) % S_DATA_COUNT;

        case (state_q)
            ST_IDLE: begin
                arb_en = |req_i;
            end
            ST_LOCKED: begin
                // Packet completion: advance pointer and re-arbitrate on the same edge,
                // excluding the finishing source so it cannot win twice in a row.
                if (beat && last_i[idx_q]) begin
                    ptr_d          = IDX_W'(next_ptr);
                    arb_ptr        = IDX_W'(next_ptr);
                    arb_cand[idx_q] = 1'b0;
                    arb_en         = 1'b1;
                end
            end
            default: ;
        endcase

        for (int k = 0; k < S_DATA_COUNT; k++) begin
            pos = (int'(arb_ptr) + k) % S_DATA_COUNT;
            if (!found && arb_cand[pos]) begin
                found = 1'b1;
                win   = IDX_W'(pos);
            end
        end

        if (arb_en) begin
            if (found) begin
                state_d = ST_LOCKED;
                valid_d = 1'b1;
                idx_d   = win;
            end else begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                idx_d   = '0;
            end
        end

        grant_d = '0;
        if (valid_d) begin
            grant_d[idx_d] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    assign grant_o       = grant_q;
    assign grant_valid_o = valid_q;
    assign grant_idx_o   = idx_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed vector bench for stream_rr_arbiter with S_DATA_COUNT=2 and S_DATA_COUNT=3 instances.
module tb_stream_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic       ready;
    logic [1:0] req2, last2;
    logic [2:0] req3, last3;
    logic [1:0] grant2;
    logic       valid2;
    logic [0:0] idx2;
    logic [2:0] grant3;
    logic       valid3;
    logic [1:0] idx3;

    int checks   = 0;
    int failures = 0;

    stream_rr_arbiter #(.S_DATA_COUNT(2)) u2 (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req2), .last_i(last2), .ready_i(ready),
        .grant_o(grant2), .grant_valid_o(valid2), .grant_idx_o(idx2)
    );

    stream_rr_arbiter #(.S_DATA_COUNT(3)) u3 (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req3), .last_i(last3), .ready_i(ready),
        .grant_o(grant3), .grant_valid_o(valid3), .grant_idx_o(idx3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       sel3;
        logic [2:0] req;
        logic [2:0] last;
        logic       rdy;
        logic [2:0] g;
        logic       v;
        logic [1:0] idx;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    task automatic check2(input string nm, input int g, input int v, input int i);
        check({nm, ".grant"}, int'(grant2), g);
        check({nm, ".valid"}, int'(valid2), v);
        check({nm, ".idx"},   int'(idx2),   i);
    endtask

    task automatic check3(input string nm, input int g, input int v, input int i);
        check({nm, ".grant"}, int'(grant3), g);
        check({nm, ".valid"}, int'(valid3), v);
        check({nm, ".idx"},   int'(idx3),   i);
    endtask

    task automatic run_table();
        for (int n = 0; n < tbl.size(); n++) begin
            if (tbl[n].sel3) begin
                req3  = tbl[n].req;
                last3 = tbl[n].last;
                req2  = 2'b00;
                last2 = 2'b00;
            end else begin
                req2  = tbl[n].req[1:0];
                last2 = tbl[n].last[1:0];
                req3  = 3'b000;
                last3 = 3'b000;
            end
            ready = tbl[n].rdy;
            @(posedge clk);
            #1;
            if (tbl[n].sel3)
                check3($sformatf("s3_vec%0d", n), int'(tbl[n].g), int'(tbl[n].v), int'(tbl[n].idx));
            else
                check2($sformatf("s2_vec%0d", n), int'(tbl[n].g), int'(tbl[n].v), int'(tbl[n].idx));
        end
        tbl.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        req2  = 2'b11;
        last2 = 2'b00;
        req3  = 3'b111;
        last3 = 3'b000;
        ready = 1'b1;

        // Reset with requests present: outputs must stay cleared through edges.
        @(posedge clk);
        @(posedge clk);
        #1;
        check2("reset_s2", 0, 0, 0);
        check3("reset_s3", 0, 0, 0);
        req2  = 2'b00;
        req3  = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;

        // S=2: single packet, contention, lock under backpressure, masked re-arbitration.
        //          sel3  req     last    rdy   grant   v     idx
        tbl.push_back('{1'b0, 3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 2'd0});
        tbl.push_back('{1'b0, 3'b001, 3'b000, 1'b1, 3'b001, 1'b1, 2'd0});
        tbl.push_back('{1'b0, 3'b001, 3'b000, 1'b1, 3'b001, 1'b1, 2'd0});
        tbl.push_back('{1'b0, 3'b001, 3'b000, 1'b1, 3'b001, 1'b1, 2'd0});
        tbl.push_back('{1'b0, 3'b001, 3'b001, 1'b1, 3'b000, 1'b0, 2'd0});
        tbl.push_back('{1'b0, 3'b011, 3'b011, 1'b1, 3'b010, 1'b1, 2'd1});
        tbl.push_back('{1'b0, 3'b011, 3'b011, 1'b1, 3'b001, 1'b1, 2'd0});
        tbl.push_back('{1'b0, 3'b011, 3'b011, 1'b1, 3'b010, 1'b1, 2'd1});
        tbl.push_back('{1'b0, 3'b011, 3'b011, 1'b1, 3'b001, 1'b1, 2'd0});
        tbl.push_back('{1'b0, 3'b011, 3'b001, 1'b1, 3'b010, 1'b1, 2'd1});
        tbl.push_back('{1'b0, 3'b011, 3'b000, 1'b1, 3'b010, 1'b1, 2'd1});
        tbl.push_back('{1'b0, 3'b011, 3'b011, 1'b0, 3'b010, 1'b1, 2'd1});
        tbl.push_back('{1'b0, 3'b011, 3'b011, 1'b0, 3'b010, 1'b1, 2'd1});
        tbl.push_back('{1'b0, 3'b011, 3'b011, 1'b0, 3'b010, 1'b1, 2'd1});
        tbl.push_back('{1'b0, 3'b011, 3'b011, 1'b0, 3'b010, 1'b1, 2'd1});
        tbl.push_back('{1'b0, 3'b001, 3'b010, 1'b1, 3'b010, 1'b1, 2'd1});
        tbl.push_back('{1'b0, 3'b011, 3'b010, 1'b1, 3'b001, 1'b1, 2'd0});
        tbl.push_back('{1'b0, 3'b010, 3'b000, 1'b1, 3'b001, 1'b1, 2'd0});
        tbl.push_back('{1'b0, 3'b001, 3'b001, 1'b1, 3'b000, 1'b0, 2'd0});
        tbl.push_back('{1'b0, 3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 2'd0});
        tbl.push_back('{1'b0, 3'b001, 3'b000, 1'b1, 3'b001, 1'b1, 2'd0});
        tbl.push_back('{1'b0, 3'b001, 3'b001, 1'b1, 3'b000, 1'b0, 2'd0});
        run_table();

        // Reset mid-packet on s=1: outputs clear without waiting for a clock edge.
        req2  = 2'b10;
        last2 = 2'b00;
        ready = 1'b0;
        @(posedge clk);
        #1;
        check2("lock_s1", 2, 1, 1);
        ready = 1'b1;
        @(posedge clk);
        #1;
        check2("mid_pkt_s1", 2, 1, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check2("async_rst", 0, 0, 0);
        @(posedge clk);
        #1;
        check2("rst_held", 0, 0, 0);
        req2 = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check2("post_rst_ptr0", 1, 1, 0);
        req2 = 2'b00;

        // S=3: wrap-around, sole requester finishing goes idle, masked scan order.
        tbl.push_back('{1'b1, 3'b100, 3'b000, 1'b1, 3'b100, 1'b1, 2'd2});
        tbl.push_back('{1'b1, 3'b100, 3'b000, 1'b0, 3'b100, 1'b1, 2'd2});
        tbl.push_back('{1'b1, 3'b111, 3'b100, 1'b1, 3'b001, 1'b1, 2'd0});
        tbl.push_back('{1'b1, 3'b001, 3'b001, 1'b1, 3'b000, 1'b0, 2'd0});
        tbl.push_back('{1'b1, 3'b100, 3'b000, 1'b1, 3'b100, 1'b1, 2'd2});
        tbl.push_back('{1'b1, 3'b100, 3'b100, 1'b1, 3'b000, 1'b0, 2'd0});
        tbl.push_back('{1'b1, 3'b100, 3'b000, 1'b1, 3'b100, 1'b1, 2'd2});
        tbl.push_back('{1'b1, 3'b110, 3'b100, 1'b1, 3'b010, 1'b1, 2'd1});
        tbl.push_back('{1'b1, 3'b011, 3'b010, 1'b1, 3'b001, 1'b1, 2'd0});
        tbl.push_back('{1'b1, 3'b001, 3'b001, 1'b1, 3'b000, 1'b0, 2'd0});
        run_table();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
